// File: rtl/dpm_stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : dpm_stream_fifo
//  Summary  : Valid/ready FIFO controller around a two-port registered-read
//             RAM (port A writes, port B reads). A 2-entry output buffer
//             hides the RAM read latency so 1 word/clk flows in and out.
//  Revision : 1.0  initial release
// ============================================================================
module dpm_stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+2):0]   level,
    output logic                       mem_wr_en,
    output logic [AW-1:0]              mem_wr_addr,
    output logic [WIDTH-1:0]           mem_wr_data,
    output logic [AW-1:0]              mem_rd_addr,
    input  logic [WIDTH-1:0]           mem_rd_data
);

    localparam int             c_LW   = $clog2(DEPTH+2) + 1;
    localparam logic [AW:0]    c_FULL = 1'b1 << AW;

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_mem_count;
    logic [1:0]       r_ob_count;
    logic             r_rd_inflight;
    logic [WIDTH-1:0] r_ob0;
    logic [WIDTH-1:0] r_ob1;

    logic             w_push;
    logic             w_pop;
    logic             w_rd_issue;
    logic [2:0]       w_ob_pending;

    // in_ready depends on registered state only; push is also blocked in reset
    assign in_ready    = (r_mem_count < c_FULL);
    assign w_push      = in_valid & in_ready & ~rst;
    assign out_valid   = (r_ob_count != 2'd0);
    assign w_pop       = out_valid & out_ready;
    assign out_data    = r_ob0;

    // Buffer slots already committed once this cycle's pop is accounted for
    assign w_ob_pending = {1'b0, r_ob_count} + {2'b00, r_rd_inflight} - {2'b00, w_pop};
    assign w_rd_issue   = (r_mem_count != '0) && (w_ob_pending < 3'd2);

    assign mem_wr_en   = w_push;
    assign mem_wr_addr = r_wr_ptr;
    assign mem_wr_data = in_data;
    assign mem_rd_addr = r_rd_ptr;

    assign level = c_LW'(r_mem_count) + c_LW'(r_rd_inflight) + c_LW'(r_ob_count);

    // RAM-side pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_mem_count   <= '0;
            r_rd_inflight <= 1'b0;
        end else begin
            r_rd_inflight <= w_rd_issue;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_issue) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_rd_issue})
                2'b10:   r_mem_count <= r_mem_count + (AW+1)'(1);
                2'b01:   r_mem_count <= r_mem_count - (AW+1)'(1);
                default: r_mem_count <= r_mem_count;
            endcase
        end
    end

    // Output buffer occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ob_count <= 2'd0;
        end else begin
            case ({w_pop, r_rd_inflight})
                2'b10:   r_ob_count <= r_ob_count - 2'd1;
                2'b01:   r_ob_count <= r_ob_count + 2'd1;
                default: r_ob_count <= r_ob_count;
            endcase
        end
    end

    // Output buffer data; returned words land behind whatever survives the pop
    always_ff @(posedge clk) begin
        if (!rst) begin
            case ({w_pop, r_rd_inflight})
                2'b10: begin
                    r_ob0 <= r_ob1;
                end
                2'b01: begin
                    if (r_ob_count == 2'd0) begin
                        r_ob0 <= mem_rd_data;
                    end else begin
                        r_ob1 <= mem_rd_data;
                    end
                end
                2'b11: begin
                    if (r_ob_count == 2'd1) begin
                        r_ob0 <= mem_rd_data;
                    end else begin
                        r_ob0 <= r_ob1;
                        r_ob1 <= mem_rd_data;
                    end
                end
                default: begin
                    r_ob0 <= r_ob0;
                    r_ob1 <= r_ob1;
                end
            endcase
        end
    end

    a_ob_bound: assert property (@(posedge clk) disable iff (rst)
        (r_ob_count <= 2'd2));
    a_mem_bound: assert property (@(posedge clk) disable iff (rst)
        (r_mem_count <= c_FULL));

endmodule
`default_nettype wire
